// File: rtl/gate_equiv_checker.sv
// gate_equiv_checker: exhaustively drives a pair of N_IN-input NAND gates and flags disagreements with NAND.
//   in : clk, rst (sync, active-high), start, abort, dut_e_o / dut_c_o (gate outputs under test)
//   out: stim (gate inputs), busy, done, pass, mismatch_cnt, first_fail, err_e, err_c
module gate_equiv_checker #(
  parameter int N_IN = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_e_o,
  input  logic            dut_c_o,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            err_e,
  output logic            err_c
);
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  state_t          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d, ff_q, ff_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic            err_e_q, err_e_d, err_c_q, err_c_d, pass_q, pass_d;
  logic            bad_e, bad_c, last;
  assign bad_e = dut_e_o != ~&stim_q;
  assign bad_c = dut_c_o != ~&stim_q;
  assign last  = &stim_q;
  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    ff_d    = ff_q;
    err_e_d = err_e_q;
    err_c_d = err_c_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = APPLY;
        stim_d  = '0;
        cnt_d   = '0;
        ff_d    = '0;
        err_e_d = 1'b0;
        err_c_d = 1'b0;
        pass_d  = 1'b0;
      end
      APPLY: begin
        state_d = abort ? IDLE : CHECK;
        stim_d  = abort ? '0 : stim_q;
        pass_d  = abort ? 1'b0 : pass_q;
      end
      CHECK: if (abort) begin
        state_d = IDLE;
        stim_d  = '0;
        pass_d  = 1'b0;
      end else begin
        // a vector counts once even when both gates are wrong
        cnt_d   = (bad_e | bad_c) ? cnt_q + 1'b1 : cnt_q;
        ff_d    = ((bad_e | bad_c) && cnt_q == '0) ? stim_q : ff_q;
        err_e_d = err_e_q | bad_e;
        err_c_d = err_c_q | bad_c;
        state_d = last ? DONE : APPLY;
        stim_d  = last ? stim_q : stim_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        stim_d  = '0;
        pass_d  = cnt_q == '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      ff_q    <= '0;
      err_e_q <= 1'b0;
      err_c_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      ff_q    <= ff_d;
      err_e_q <= err_e_d;
      err_c_q <= err_c_d;
      pass_q  <= pass_d;
    end
  end
  assign stim         = stim_q;
  assign busy         = state_q == APPLY || state_q == CHECK;
  assign done         = state_q == DONE;
  assign pass         = pass_q;
  assign mismatch_cnt = cnt_q;
  assign first_fail   = ff_q;
  assign err_e        = err_e_q;
  assign err_c        = err_c_q;
endmodule

// File: tb/tb_gate_equiv_checker.sv
// tb_gate_equiv_checker: random runs with injected gate faults, checked against a run-level model.
module tb_gate_equiv_checker;
  localparam int N  = 5;
  localparam int NV = 2 ** N;
  localparam int T  = 2 ** (N + 1) + 1;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic dut_e, dut_c;
  logic [N-1:0] stim, first_fail;
  logic [N:0] mismatch_cnt;
  logic busy, done, pass, err_e, err_c;
  logic ebad [0:NV-1];
  logic cbad [0:NV-1];
  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0, done_at = -1;
  bit run = 0;
  int t = 0;
  int hc = 0, hf = 0;
  bit he = 0, hec = 0, hp = 0;
  int mode = 0;
  bit rnd_mode = 0;
  bit fin2 = 0;
  always #5 clk = ~clk;
  assign dut_e = ~(&stim) ^ ebad[stim];
  assign dut_c = ~(&stim) ^ cbad[stim];
  gate_equiv_checker #(.N_IN(N)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_e_o(dut_e), .dut_c_o(dut_c),
    .stim(stim), .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
    .first_fail(first_fail), .err_e(err_e), .err_c(err_c));
  logic rst2 = 1'b1, start2 = 1'b0;
  logic [1:0] stim2, ff2;
  logic [2:0] cnt2;
  logic busy2, done2, pass2, ee2, ec2;
  gate_equiv_checker #(.N_IN(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .abort(1'b0), .dut_e_o(~&stim2), .dut_c_o(~&stim2),
    .stim(stim2), .busy(busy2), .done(done2), .pass(pass2), .mismatch_cnt(cnt2),
    .first_fail(ff2), .err_e(ee2), .err_c(ec2));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  function automatic void gen_faults(input int m);
    for (int v = 0; v < NV; v++) begin
      logic n;
      n = (v != NV - 1);
      ebad[v] = (m == 2) ? !n : (m == 3 || m == 4) ? ($urandom_range(0, 7) == 0) : 1'b0;
      cbad[v] = (m == 1) ? n : (m == 4) ? ($urandom_range(0, 7) == 0) : 1'b0;
    end
  endfunction
  // results after every vector whose check cycle has completed by cycle tt
  function automatic void calc(input int tt, output int c, output int f, output bit ee, output bit ec);
    c = 0; f = 0; ee = 0; ec = 0;
    for (int v = 0; v < NV; v++)
      if (3 + 2 * v <= tt) begin
        if (ebad[v] || cbad[v]) begin
          if (c == 0) f = v;
          c++;
        end
        ee |= ebad[v];
        ec |= cbad[v];
      end
  endfunction
  task automatic step(input logic r, input logic s, input logic a);
    int c, f, xs;
    bit ee, ec, xb, xd, xp;
    @(negedge clk);
    cyc++;
    if (done === 1'b1) done_at = cyc - start_cyc;
    if (run) begin
      calc(t, c, f, ee, ec);
      xb = t < T; xd = t == T; xs = (t < T) ? (t - 1) / 2 : NV - 1; xp = 0;
    end else begin
      c = hc; f = hf; ee = he; ec = hec; xb = 0; xd = 0; xs = 0; xp = hp;
    end
    chk("busy", busy, xb);
    chk("done", done, xd);
    chk("stim", stim, xs);
    chk("pass", pass, xp);
    chk("mismatch_cnt", mismatch_cnt, c);
    chk("first_fail", first_fail, f);
    chk("err_e", err_e, ee);
    chk("err_c", err_c, ec);
    rst = r; start = s; abort = a;
    if (r) begin
      run = 0; hc = 0; hf = 0; he = 0; hec = 0; hp = 0;
    end else if (run) begin
      if (t == T) begin
        run = 0; calc(t, hc, hf, he, hec); hp = (hc == 0);
      end else if (a) begin
        run = 0; calc(t, hc, hf, he, hec); hp = 0;
      end else t++;
    end else if (s) begin
      run = 1; t = 1; start_cyc = cyc;
      if (rnd_mode) mode = $urandom_range(0, 4);
      gen_faults(mode);
    end
  endtask
  task automatic full_run(input int m);
    mode = m;
    done_at = -1;
    step(0, 1, 0);
    repeat (T + 1) step(0, 0, 0);
  endtask
  initial begin
    gen_faults(0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cnt", mismatch_cnt, 0);
    full_run(0);
    chk("good_done_at", done_at, 65);
    chk("good_pass", pass, 1);
    chk("good_cnt", mismatch_cnt, 0);
    chk("good_ff", first_fail, 0);
    chk("good_errs", {err_e, err_c}, 0);
    full_run(1);
    chk("c_sa0_cnt", mismatch_cnt, 31);
    chk("c_sa0_ff", first_fail, 0);
    chk("c_sa0_errs", {err_e, err_c}, 2'b01);
    chk("c_sa0_pass", pass, 0);
    full_run(2);
    chk("e_sa1_cnt", mismatch_cnt, 1);
    chk("e_sa1_ff", first_fail, 5'b11111);
    chk("e_sa1_errs", {err_e, err_c}, 2'b10);
    chk("e_sa1_pass", pass, 0);
    mode = 3; done_at = -1;
    step(0, 1, 0);
    for (int k = 1; k < 20; k++) step(0, k % 3 == 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_stim", stim, 0);
    chk("abort_pass", pass, 0);
    repeat (5) step(0, 0, 0);
    chk("abort_no_done", done_at, -1);
    mode = 4;
    step(0, 1, 0);
    repeat (29) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("rst_cnt", mismatch_cnt, 0);
    chk("rst_busy", busy, 0);
    full_run(0);
    chk("after_rst_done_at", done_at, 65);
    chk("after_rst_pass", pass, 1);
    rnd_mode = 1;
    for (int k = 0; k < 4000; k++)
      step($urandom_range(0, 699) == 0,
           $urandom_range(0, 3) == 0,
           run ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 9) == 0));
    for (int k = 0; k < 200 && !fin2; k++) @(negedge clk);
    chk("n2_finished", fin2, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    int seq [0:3];
    int d2 = -1;
    seq = '{0, 1, 2, 3};
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k % 2 == 1 && k < 9) chk("n2_stim", stim2, seq[(k - 1) / 2]);
      if (done2 === 1'b1) d2 = k;
      if (k == 10) chk("n2_pass", pass2, 1);
      @(negedge clk);
    end
    chk("n2_done_at", d2, 9);
    fin2 = 1;
  end
endmodule

// File: doc/gate_equiv_checker.md
GATE_EQUIV_CHECKER -- requirements
Module: gate_equiv_checker

Interface
REQ-001 The module SHALL have parameter N_IN, default 5, giving the input count of the gate pair under test (legal range 2..8).
REQ-002 The module SHALL have clock and reset as follows: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  run request, sampled only in IDLE.
REQ-006 abort  input  1  run cancel, sampled only in APPLY/CHECK.
REQ-007 dut_e_o  input  1  output of the behavioural NAND gate under test.
REQ-008 dut_c_o  input  1  output of the structural NAND gate under test.
REQ-009 stim  output  N_IN  registered gate stimulus; bit 0 drives i1, bit N_IN-1 drives iN.
REQ-010 busy  output  1  high in APPLY and CHECK.
REQ-011 done  output  1  one-cycle pulse when a run completes.
REQ-012 pass  output  1  result of last completed run: 1 = no mismatch.
REQ-013 mismatch_cnt  output  N_IN+1  number of vectors that failed in current/last run.
REQ-014 first_fail  output  N_IN  stim value of first failing vector; 0 if none.
REQ-015 err_e  output  1  sticky: dut_e_o mismatched at least once this run.
REQ-016 err_c  output  1  sticky: dut_c_o mismatched at least once this run.

Function
REQ-017 FSM states SHALL be IDLE, APPLY, CHECK, DONE; encoding is implementer's choice.
REQ-018 IDLE: start=1 -> APPLY; stim<=0, mismatch_cnt<=0, first_fail<=0, err_e<=0, err_c<=0, pass<=0; start=0 -> stay, all result outputs hold.
REQ-019 APPLY: exactly one cycle, stim held stable for gate settling; abort=0 -> CHECK.
REQ-020 CHECK: expected = NOT(AND of all stim bits); compare dut_e_o and dut_c_o against expected in this cycle.
REQ-021 CHECK mismatch (either gate differs): mismatch_cnt increments by 1; first_fail<=stim only on the first mismatch of the run; err_e / err_c set per offending gate; both wrong counts as one vector.
REQ-022 CHECK, stim != all-ones, abort=0: stim<=stim+1 -> APPLY.
REQ-023 CHECK, stim == all-ones, abort=0: stim holds -> DONE; no wrap-around to 0.
REQ-024 DONE: done=1 for exactly this cycle; pass<=1 iff final mismatch_cnt==0 (including a mismatch on the last vector); -> IDLE; stim<=0.
REQ-025 abort=1 in APPLY or CHECK SHALL take priority over comparison: no count update that cycle, -> IDLE, stim<=0, pass<=0, done not asserted; other results hold.
REQ-026 start while busy or in DONE SHALL be ignored.
REQ-027 Run timing: start accepted at edge 0 -> vector v in APPLY at cycle 1+2v, CHECK at 2+2v; done high in cycle 2^(N_IN+1)+1 (65 for N_IN=5).
REQ-028 mismatch_cnt SHALL not overflow (max 2^N_IN fits N_IN+1 bits).
REQ-029 All outputs SHALL be driven from registers except busy and done, which decode state only.

Reset
REQ-030 rst=1 at any edge, including mid-run, SHALL force IDLE, stim=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail=0, err_e=0, err_c=0; rst has priority over start and abort.
REQ-031 First start SHALL be accepted in the cycle after rst deasserts.

Verification
REQ-032 N_IN=5, both gates correct NAND5 -> done in cycle 65, pass=1, mismatch_cnt=0, err_e=0, err_c=0, first_fail=0.
REQ-033 dut_c_o stuck-at-0 -> mismatch_cnt=31, first_fail=0, err_c=1, err_e=0, pass=0.
REQ-034 dut_e_o stuck-at-1 -> mismatch_cnt=1, first_fail=5'b11111, err_e=1, pass=0 (last-vector mismatch).
REQ-035 abort=1 in cycle 20 -> busy=0 in cycle 21, stim=0, pass=0, no done pulse; start pulses during run ignored.
REQ-036 rst asserted in cycle 30 of a run -> all reset values next cycle; new start then completes normally.
REQ-037 N_IN=2 with correct NAND2 -> done in cycle 9, pass=1, stim sequence 0,1,2,3.
